// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, response and RAM-port signals of mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_byte;
  logic                  req_signed;
  logic [ADDR_WIDTH:0]   req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
  );
  modport slave (
    input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/word load-store controller in front of a single-port synchronous block RAM.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;
  state_t                r_state, w_next;
  logic                  r_we, r_byte, r_signed, r_err;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_merge, w_load;
  logic [7:0]            w_lane;
  logic                  w_accept, w_misaligned;
  assign bus.req_ready  = r_state == IDLE && !reset;
  assign w_accept       = bus.req_valid && bus.req_ready;
  assign w_misaligned   = !bus.req_byte && bus.req_addr[0];
  assign bus.mem_addr   = r_state == IDLE ? '0 : r_addr[ADDR_WIDTH:1];
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_we     = r_state == WRITE;
  assign bus.rsp_valid  = r_state == DONE;
  assign bus.rsp_err    = r_err;
  assign bus.rsp_rdata  = r_rdata;
  assign w_lane = bus.mem_rdata[{r_addr[0], 3'b000} +: 8];
  assign w_load = r_byte ? {{(DATA_WIDTH-8){r_signed & w_lane[7]}}, w_lane} : bus.mem_rdata;
  always_comb begin
    w_merge = bus.mem_rdata;
    w_merge[{r_addr[0], 3'b000} +: 8] = r_wdata[7:0];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : w_misaligned ? DONE :
                        (bus.req_we && !bus.req_byte) ? WRITE : READ;
      READ:    w_next = CAPTURE;
      CAPTURE: w_next = r_we ? WRITE : DONE;
      WRITE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // response registers change only on entry to DONE so they hold between completions
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we     <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_byte   <= bus.req_byte;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
      if (r_state == CAPTURE && r_we) r_wdata <= w_merge;
      if (w_next == DONE) begin
        r_err   <= r_state == IDLE;
        r_rdata <= (r_state == CAPTURE && !r_we) ? w_load : '0;
      end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-array memory model.
module tb_mem_access_ctrl;
  localparam int DW = 16, AW = 10, NW = 1 << AW, NB = 1 << (AW + 1);
  logic clk = 1'b0, reset = 1'b1, preload = 1'b1;
  int checks = 0, errors = 0, n_rsp = 0, n_we = 0;
  logic [DW-1:0] ram  [NW];
  logic [DW-1:0] seed [NW];
  logic [7:0]    ref_b [NB];
  logic          rv [9], rdy [9];
  logic [DW-1:0] rd [9];
  logic [AW-1:0] ma [9];
  logic [DW-1:0] w0, w2;
  int rsp0, we0;
  mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < NW; i++) ram[i] <= seed[i];
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  always @(negedge clk) begin
    if (bus.rsp_valid) n_rsp++;
    if (bus.mem_we) n_we++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] ref_word(input logic [AW:0] a);
    return {ref_b[{a[AW:1], 1'b1}], ref_b[{a[AW:1], 1'b0}]};
  endfunction
  task automatic do_req(input logic we, input logic byt, input logic sgn,
                        input logic [AW:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_r;
    logic          exp_e;
    logic [7:0]    b;
    int exp_lat, lat, nwe, k;
    exp_e   = !byt && a[0];
    b       = ref_b[a];
    exp_r   = (exp_e || we) ? '0 : byt ? {{8{sgn & b[7]}}, b} : ref_word(a);
    exp_lat = exp_e ? 1 : !we ? 3 : byt ? 4 : 2;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = byt; bus.req_signed = sgn;
    bus.req_addr = a; bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    check("accept_timeout", 32'(k < 20), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_byte = 1'($urandom);
    bus.req_signed = 1'($urandom); bus.req_addr = (AW+1)'($urandom); bus.req_wdata = DW'($urandom);
    lat = 0; nwe = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      check("mem_addr_busy", bus.mem_addr, a[AW:1]);
      check("ready_busy", bus.req_ready, 0);
      if (bus.mem_we) nwe++;
      if (bus.rsp_valid) begin
        lat = i;
        check("rsp_err", bus.rsp_err, exp_e);
        check("rsp_rdata", bus.rsp_rdata, exp_r);
      end
    end
    check("latency", lat, exp_lat);
    check("we_count", nwe, 32'(we && !exp_e));
    if (we && !exp_e) begin
      ref_b[a] = wd[7:0];
      if (!byt) ref_b[{a[AW:1], 1'b1}] = wd[15:8];
    end
    check("ram_word", ram[a[AW:1]], ref_word(a));
    @(negedge clk);
    check("rsp_pulse_end", bus.rsp_valid, 0);
    check("ready_idle", bus.req_ready, 1);
    check("mem_addr_idle", bus.mem_addr, 0);
    check("rdata_hold", bus.rsp_rdata, exp_r);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < NW; i++) begin
      seed[i] = DW'($urandom);
      ref_b[2*i] = seed[i][7:0];
      ref_b[2*i+1] = seed[i][15:8];
    end
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    preload = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1);
    do_req(1, 0, 0, 11'h000, 16'h000F);
    do_req(0, 0, 0, 11'h000, 16'h0000);
    check("word_load_0", bus.rsp_rdata, 16'h000F);
    do_req(1, 0, 0, 11'h002, 16'h80F0);
    do_req(0, 1, 1, 11'h003, 16'h0000);
    check("byte_hi_signed", bus.rsp_rdata, 16'hFF80);
    do_req(0, 1, 0, 11'h003, 16'h0000);
    check("byte_hi_unsigned", bus.rsp_rdata, 16'h0080);
    do_req(0, 1, 1, 11'h002, 16'h0000);
    check("byte_lo_signed", bus.rsp_rdata, 16'hFFF0);
    do_req(1, 0, 0, 11'h004, 16'h3000);
    do_req(1, 1, 0, 11'h004, 16'h12AB);
    check("byte_store_lo", ram[2], 16'h30AB);
    do_req(1, 1, 0, 11'h005, 16'h34CD);
    check("byte_store_hi", ram[2], 16'hCDAB);
    do_req(0, 0, 0, 11'h007, 16'h0000);
    check("misaligned_err", bus.rsp_err, 1);
    do_req(1, 0, 0, 11'h009, 16'hBEEF);
    do_req(1, 1, 0, 11'h7FF, 16'h005A);
    check("top_byte_ram", ram[NW-1][15:8], 8'h5A);
    do_req(0, 1, 1, 11'h7FF, 16'h0000);
    check("top_byte_load", bus.rsp_rdata, 16'h005A);
    do_req(1, 0, 0, 11'h006, 16'h0C00);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_byte = 1'b1; bus.req_signed = 1'b0;
    bus.req_addr = 11'h006; bus.req_wdata = 16'h0055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    rsp0 = n_rsp; we0 = n_we;
    repeat (3) begin
      @(negedge clk);
      check("abort_ready", bus.req_ready, 0);
      check("abort_rsp_valid", bus.rsp_valid, 0);
      check("abort_mem_we", bus.mem_we, 0);
    end
    check("abort_rdata", bus.rsp_rdata, 0);
    check("abort_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", bus.req_ready, 1);
    check("abort_no_rsp", n_rsp - rsp0, 0);
    check("abort_no_we", n_we - we0, 0);
    check("abort_ram", ram[3], 16'h0C00);
    do_req(1, 0, 0, 11'h000, 16'h1234);
    do_req(1, 0, 0, 11'h004, 16'h5678);
    w0 = ref_word(11'h000); w2 = ref_word(11'h004);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 11'h000; bus.req_wdata = DW'($urandom);
    @(posedge clk);
    #1 bus.req_addr = 11'h004;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rv[i] = bus.rsp_valid; rdy[i] = bus.req_ready; rd[i] = bus.rsp_rdata; ma[i] = bus.mem_addr;
      if (i == 4) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0; bus.req_addr = 11'h002;
      end
    end
    for (int i = 1; i <= 8; i++) begin
      check("b2b_valid", rv[i], 32'(i == 3 || i == 7));
      check("b2b_ready", rdy[i], 32'(i == 4 || i == 8));
      if (i != 4 && i != 8) check("b2b_addr", ma[i], (i < 4) ? 0 : 2);
    end
    check("b2b_rdata0", rd[3], w0);
    check("b2b_rdata2", rd[7], w2);
    for (int n = 0; n < 60; n++) begin
      logic [AW:0] a;
      a = (n % 10 == 9) ? (AW+1)'(NB - 1) : (AW+1)'($urandom_range(0, NB - 1));
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, DW'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
